param_univ_reg: RTL

Parametrised universal register: the successor to the single-bit D flip-flop in the sequential-elements set. It extends the plain D/Q storage element to a WIDTH-bit register with enable, parallel load, serial shifts, rotates and up/down counting. It carries a serial-out bit, a wrap (carry/borrow) pulse and a zero flag. It is the building block for shift chains, small counters and serial/parallel converters.

---
 rtl/param_univ_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/param_univ_reg.sv
// ----------------------------------------------------------------------------
// param_univ_reg
//
// Parametrised universal register. A WIDTH-bit storage element with enable,
// parallel load, serial shift left/right, rotate left/right and up/down
// counting. A serial-out bit records the last bit that left the register,
// a wrap pulse marks counter overflow/underflow, and a zero flag reports an
// all-zero register. Typical uses are shift chains, small counters and
// serial/parallel converters.
//
// Parameters
//   WIDTH    register width in bits (WIDTH >= 2)
//   RST_VAL  value loaded into Q by reset
//
// Ports
//   Clk   in   1      clock, all state changes on the rising edge
//   rst   in   1      synchronous active-high reset
//   en    in   1      operation enable, register holds when low
//   mode  in   3      operation select
//   D     in   WIDTH  parallel load data
//   SI    in   1      serial input for the shift operations
//   Q     out  WIDTH  registered contents
//   SO    out  1      last bit shifted or rotated out (registered)
//   CO    out  1      single-cycle wrap pulse from increment/decrement
//   Z     out  1      combinational flag, high when Q is all zeros
// ----------------------------------------------------------------------------
module param_univ_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             CO,
    output logic             Z
);

    // Operation encodings carried on the mode input.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] regQ_q,  regQ_d;
    logic             serOut_q, serOut_d;
    logic             wrap_q,  wrap_d;

    // One extra bit on the counter arithmetic exposes the carry (increment)
    // or borrow (decrement) out of the top bit. For the decrement, the extra
    // bit goes high only when the register was zero, i.e. exactly on the
    // underflow wrap.
    logic [WIDTH:0]   incSum;
    logic [WIDTH:0]   decDiff;

    // Counter arithmetic, always computed; only used in the counting modes.
    always_comb begin
        incSum  = {1'b0, regQ_q} + (WIDTH+1)'(1);
        decDiff = {1'b0, regQ_q} - (WIDTH+1)'(1);
    end

    // Next-state selection. The serial-out bit and the register hold by
    // default; the wrap pulse defaults to zero so it can only ever last a
    // single cycle, and it is cleared whenever en is low.
    always_comb begin
        regQ_d   = regQ_q;
        serOut_d = serOut_q;
        wrap_d   = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: begin
                    regQ_d = regQ_q;
                end
                MODE_LOAD: begin
                    regQ_d = D;
                end
                MODE_SHL: begin
                    regQ_d   = {regQ_q[WIDTH-2:0], SI};
                    serOut_d = regQ_q[WIDTH-1];
                end
                MODE_SHR: begin
                    regQ_d   = {SI, regQ_q[WIDTH-1:1]};
                    serOut_d = regQ_q[0];
                end
                MODE_ROL: begin
                    regQ_d   = {regQ_q[WIDTH-2:0], regQ_q[WIDTH-1]};
                    serOut_d = regQ_q[WIDTH-1];
                end
                MODE_ROR: begin
                    regQ_d   = {regQ_q[0], regQ_q[WIDTH-1:1]};
                    serOut_d = regQ_q[0];
                end
                MODE_INC: begin
                    regQ_d = incSum[WIDTH-1:0];
                    wrap_d = incSum[WIDTH];
                end
                MODE_DEC: begin
                    regQ_d = decDiff[WIDTH-1:0];
                    wrap_d = decDiff[WIDTH];
                end
                default: begin
                    regQ_d = regQ_q;
                end
            endcase
        end
    end

    // State registers. Reset is synchronous and overrides any operation on
    // the same edge, including a counter wrap.
    always_ff @(posedge Clk) begin
        if (rst) begin
            regQ_q   <= RST_VAL;
            serOut_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            regQ_q   <= regQ_d;
            serOut_q <= serOut_d;
            wrap_q   <= wrap_d;
        end
    end

    // Outputs: everything is registered except the zero flag, which tracks
    // the register contents within the same cycle.
    always_comb begin
        Q  = regQ_q;
        SO = serOut_q;
        CO = wrap_q;
        Z  = (regQ_q == '0);
    end

endmodule
